// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory port between fetch (IF) and load/store (LS).
// Ports: IF req/addr/gnt/rvalid/rdata, LS req/we/addr/wdata/gnt/rvalid/rdata,
//   memory side mem_addr/mem_wdata/mem_we out, mem_rdata in (combinational read).
// Optional macro MEM_ARB_PERF_EN adds if_stall_cnt and ls_grant_cnt outputs.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
`ifdef MEM_ARB_PERF_EN
   output logic [31:0]       if_stall_cnt,
   output logic [31:0]       ls_grant_cnt,
`endif
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RESP_IF = 2'd1;
   localparam logic [1:0] S_RESP_LS = 2'd2;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_starve_cnt;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_ls_rdata;

   logic              w_starved;
   logic              w_ls_gnt;
   logic              w_if_gnt;
   logic [ADDR_W-1:0] w_if_addr_al;
   logic [ADDR_W-1:0] w_ls_addr_al;
   logic              w_unused;

   // Byte-offset bits are dropped: accesses always hit the aligned word.
   assign w_unused     = ^{if_addr[1:0], ls_addr[1:0]};
   assign w_if_addr_al = {if_addr[ADDR_W-1:2], 2'b00};
   assign w_ls_addr_al = {ls_addr[ADDR_W-1:2], 2'b00};

   // IF has waited through STARVE_MAX LS grants: it must win this cycle.
   assign w_starved = if_req && (r_starve_cnt == CNT_MAX);
   assign w_ls_gnt  = !reset && ls_req && !w_starved;
   assign w_if_gnt  = !reset && if_req && !w_ls_gnt;

   assign if_gnt = w_if_gnt;
   assign ls_gnt = w_ls_gnt;

   always_comb begin
      mem_addr = '0;
      if (w_ls_gnt) begin
         mem_addr = w_ls_addr_al;
      end else if (w_if_gnt) begin
         mem_addr = w_if_addr_al;
      end
   end

   assign mem_wdata = ls_wdata;
   assign mem_we    = w_ls_gnt && ls_we;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_starve_cnt <= '0;
      end else if (!if_req || w_if_gnt) begin
         r_starve_cnt <= '0;
      end else if (w_ls_gnt && (r_starve_cnt != CNT_MAX)) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   // Next state depends only on this cycle's winner, so back-to-back
   // responses (including IF<->LS switches) need no bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else if (w_ls_gnt) begin
         r_state <= S_RESP_LS;
      end else if (w_if_gnt) begin
         r_state <= S_RESP_IF;
      end else begin
         r_state <= S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_if_rdata <= '0;
         r_ls_rdata <= '0;
      end else begin
         if (w_if_gnt) begin
            r_if_rdata <= mem_rdata;
         end
         if (w_ls_gnt) begin
            r_ls_rdata <= ls_we ? '0 : mem_rdata;
         end
      end
   end

   assign if_rvalid = (r_state == S_RESP_IF);
   assign ls_rvalid = (r_state == S_RESP_LS);
   assign if_rdata  = r_if_rdata;
   assign ls_rdata  = r_ls_rdata;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] r_if_stall_cnt;
   logic [31:0] r_ls_grant_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_if_stall_cnt <= '0;
         r_ls_grant_cnt <= '0;
      end else begin
         if (if_req && !w_if_gnt) begin
            r_if_stall_cnt <= r_if_stall_cnt + 32'd1;
         end
         if (w_ls_gnt) begin
            r_ls_grant_cnt <= r_ls_grant_cnt + 32'd1;
         end
      end
   end

   assign if_stall_cnt = r_if_stall_cnt;
   assign ls_grant_cnt = r_ls_grant_cnt;
`endif

endmodule
